// File: rtl/trig_pkg.sv
// Shared types and constants for the trigger-pulse sequencer.
package trig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam logic MODE_CONT   = 1'b0;
  localparam logic MODE_SINGLE = 1'b1;

  // 10 us trigger, 1 s slot at the 1 MHz system clock
  localparam int DEF_PULSE_CYC  = 10;
  localparam int DEF_PERIOD_CYC = 1000000;

endpackage

// File: rtl/trig_slot_timer.sv
// Slot counter: runs 0..PERIOD_CYC-1 and wraps, with strobes for pulse end,
// the cycle before slot end, and slot end.
module trig_slot_timer
  import trig_pkg::*;
#(
  parameter int  PULSE_CYC  = DEF_PULSE_CYC,
  parameter int  PERIOD_CYC = DEF_PERIOD_CYC,
  localparam int CNT_W      = $clog2(PERIOD_CYC)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic pulse_end_o,
  output logic pre_end_o,
  output logic slot_end_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign pulse_end_o = (cnt_q == CNT_W'(PULSE_CYC - 1));
  assign pre_end_o   = (cnt_q == CNT_W'(PERIOD_CYC - 2));
  assign slot_end_o  = (cnt_q == CNT_W'(PERIOD_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = slot_end_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/trig_pulse_seq.sv
// Round-robin trigger-pulse sequencer: one fixed-width pulse per channel slot,
// continuous or single-shot frames, with busy and frame_done status.
module trig_pulse_seq
  import trig_pkg::*;
#(
  parameter int  N_CH       = 4,
  parameter int  PULSE_CYC  = DEF_PULSE_CYC,
  parameter int  PERIOD_CYC = DEF_PERIOD_CYC,
  localparam int IDX_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk_1m,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              start,
  input  logic [N_CH-1:0]   ch_mask,
  output logic [N_CH-1:0]   trig,
  output logic [IDX_W-1:0]  ch_idx,
  output logic              busy,
  output logic              frame_done
);

  if (N_CH < 1 || N_CH > 8) begin : g_chk_nch
    $error("trig_pulse_seq: N_CH must be in 1..8");
  end
  if (PULSE_CYC < 1 || PERIOD_CYC <= PULSE_CYC) begin : g_chk_timing
    $error("trig_pulse_seq: need PULSE_CYC >= 1 and PERIOD_CYC > PULSE_CYC");
  end

  state_e            state_q;
  logic [N_CH-1:0]   mask_q;
  logic              mode_q;
  logic [IDX_W-1:0]  idx_q;
  logic [N_CH-1:0]   trig_q;
  logic              busy_q;
  logic              done_q;

  logic              pulse_end;
  logic              pre_end;
  logic              slot_end;
  logic              last_slot;
  logic              frame_go;
  logic              tmr_clr;
  logic              tmr_en;
  logic [IDX_W-1:0]  idx_nxt;

  trig_slot_timer #(
    .PULSE_CYC  (PULSE_CYC),
    .PERIOD_CYC (PERIOD_CYC)
  ) u_timer (
    .clk_i       (clk_1m),
    .rst_ni      (rst),
    .clr_i       (tmr_clr),
    .en_i        (tmr_en),
    .pulse_end_o (pulse_end),
    .pre_end_o   (pre_end),
    .slot_end_o  (slot_end)
  );

  // frame_go covers both a fresh start from IDLE and the back-to-back
  // restart at the end of a continuous frame.
  always_comb begin
    last_slot = (idx_q == IDX_W'(N_CH - 1));
    idx_nxt   = idx_q + IDX_W'(1);
    tmr_clr   = !en || (state_q == ST_IDLE);
    tmr_en    = (state_q != ST_IDLE);
    if (state_q == ST_IDLE) begin
      frame_go = (mode == MODE_CONT) || start;
    end else begin
      frame_go = slot_end && last_slot && (mode_q != MODE_SINGLE);
    end
  end

  always_ff @(posedge clk_1m or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      mode_q  <= MODE_CONT;
      idx_q   <= '0;
      trig_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (!en) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      trig_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (frame_go) begin
      state_q <= ST_PULSE;
      mask_q  <= ch_mask;
      mode_q  <= mode;
      idx_q   <= '0;
      trig_q  <= ch_mask & N_CH'(1);
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_PULSE, ST_GAP: begin
          if (slot_end) begin
            done_q <= 1'b0;
            if (last_slot) begin
              state_q <= ST_IDLE;
              idx_q   <= '0;
              trig_q  <= '0;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_PULSE;
              idx_q   <= idx_nxt;
              trig_q  <= mask_q & (N_CH'(1) << idx_nxt);
            end
          end else begin
            // Registered frame_done must be armed one cycle ahead of the last cycle
            done_q <= last_slot && pre_end;
            if (state_q == ST_PULSE && pulse_end) begin
              state_q <= ST_GAP;
              trig_q  <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign trig       = trig_q;
  assign ch_idx     = idx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: doc/trig_pulse_seq.md
Name: trig_pulse_seq

Overview:
Parametrised multi-channel trigger-pulse sequencer for ultrasonic ranging sensors, running on the 1 MHz system clock. Fires a fixed-width trigger pulse on each of N_CH channels in round-robin slots so sensors never fire simultaneously. Supports continuous and single-shot frame modes, per-channel masking, and frame/busy status for the downstream echo-capture logic.

Parameters:
N_CH, 4, number of trigger channels (1..8)
PULSE_CYC, 10, trigger high time in clk_1m cycles (>=1; 10 = 10 us)
PERIOD_CYC, 1000000, slot length in cycles, one rising edge to the next (> PULSE_CYC)
CNT_W, $clog2(PERIOD_CYC), slot counter width (derived, not overridden)
IDX_W, max(1,$clog2(N_CH)), channel index width (derived)

Ports:
clk_1m  in  1  system clock, 1 MHz
rst  in  1  asynchronous active-low reset; all state cleared while low
en  in  1  global enable; low aborts any activity
mode  in  1  0 = continuous frames, 1 = single-shot frame
start  in  1  single-cycle request for one frame (mode=1 only)
ch_mask  in  N_CH  per-channel fire enable; latched at frame start
trig  out  N_CH  trigger pulses, registered
ch_idx  out  IDX_W  index of the current slot's channel
busy  out  1  high while a frame is in progress
frame_done  out  1  one-cycle pulse in the last cycle of a completed frame

Behaviour:
- Reset (rst=0, async): state IDLE; trig=0, ch_idx=0, busy=0, frame_done=0, counter=0, latched mask/mode=0.
- States: IDLE, PULSE, GAP. All outputs are registered; none is combinational from inputs.
- IDLE -> PULSE when en=1 and (mode=0 or start=1), sampled at a clock edge. On that edge: latch ch_mask and mode; ch_idx=0; counter=0; busy=1; trig[0]=ch_mask[0].
- Slot timing: counter runs 0..PERIOD_CYC-1, one slot per channel. trig[ch_idx] is high for counter 0..PULSE_CYC-1, exactly PULSE_CYC cycles. PULSE -> GAP when counter reaches PULSE_CYC-1.
- Masked channel (latched bit 0): slot still consumed with full length, trig stays 0, ch_idx still reports it. Frame length is therefore always N_CH*PERIOD_CYC.
- Slot end (counter=PERIOD_CYC-1): if ch_idx<N_CH-1, increment ch_idx, reset counter to 0, enter PULSE. If ch_idx=N_CH-1, frame_done=1 in this cycle.
- After the last slot: if latched mode=0 and en=1, start the next frame on the next cycle with no gap cycle, re-latching ch_mask and mode. Otherwise return to IDLE; busy=0 from the next cycle.
- At most one trig bit is high at any time.
- en=0 in any non-IDLE state: next edge forces IDLE; trig=0, busy=0, ch_idx=0; frame_done is not asserted. This abort takes priority over slot-end and frame_done.
- start while busy: ignored, not queued. start with mode=0: no effect beyond the continuous run. start with en=0: ignored.
- ch_mask or mode changes mid-frame: no effect until the next frame start.
- Counter never wraps past PERIOD_CYC-1; CNT_W must hold PERIOD_CYC-1.

Decomposition:
- Shared package trig_pkg: state enum (IDLE, PULSE, GAP); mode constants MODE_CONT=0, MODE_SINGLE=1; default PULSE_CYC/PERIOD_CYC constants for the 1 MHz clock.
- One sub-module: trig_slot_timer, a parametrised slot counter with clear/enable inputs and pulse_end/slot_end strobes.
- The sequencer FSM, channel index and output registers stay in trig_pulse_seq.

Test Plan:
- Reset: hold rst=0 mid-frame (N_CH=3, PULSE_CYC=2, PERIOD_CYC=5) -> trig=000, busy=0, ch_idx=0, frame_done=0 immediately; all remain 0 after release until a start.
- Single-shot, mask=111, start high in cycle t -> trig[0] high t+1..t+2, trig[1] high t+6..t+7, trig[2] high t+11..t+12; frame_done only at t+15; busy high t+1..t+15; IDLE at t+16.
- Continuous, mask=101, en held high -> trig[1] never rises; ch_idx visits 0,1,2; frame_done every 15 cycles; second frame trig[0] rises at t+16 with no gap.
- Abort: drop en during trig[1] high -> trig=000 and busy=0 on the next cycle; no frame_done; a later start begins again at channel 0.
- Ignored inputs: start pulsed mid-frame, and ch_mask changed to 000 mid-frame -> frame timing unchanged; the old mask is used until frame end; the next frame fires nothing.
- Defaults: N_CH=1, PULSE_CYC=10, PERIOD_CYC=1000000, continuous -> 10-cycle pulses with rising edges exactly 1,000,000 cycles apart over 3 periods.
